bit_population_counter_stream: RTL

BIT_POPULATION_COUNTER_STREAM -- requirements
Module: bit_population_counter_stream

---
 rtl/bit_population_counter_pkg.sv | 16 +
 rtl/bit_population_counter_stream_popcount_chunk.sv | 23 ++
 rtl/bit_population_counter_stream.sv | 129 ++++++++++++
 3 files changed

// File: rtl/bit_population_counter_pkg.sv
// Shared types and helpers for the streaming population counter.
// Holds the FSM state encoding and the result-width helper.
package bit_population_counter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_OUT   = 2'd2
  } state_t;

  // Bits needed to hold any count from 0 up to and including data_w.
  function automatic int result_width(input int data_w);
    return $clog2(data_w + 1);
  endfunction

endpackage

// File: rtl/bit_population_counter_stream_popcount_chunk.sv
// Combinational population count of one CHUNK_W-bit slice.
module popcount_chunk #(
  parameter int CHUNK_W = 4
) (
  input  logic [CHUNK_W-1:0]           bits,
  output logic [$clog2(CHUNK_W+1)-1:0] count
);

  localparam int OUT_W = $clog2(CHUNK_W + 1);

  logic [OUT_W-1:0] count_s;

  // Sum the set bits of the slice.
  always_comb begin
    count_s = {OUT_W{1'b0}};
    for (int i = 0; i < CHUNK_W; i++) begin
      count_s = count_s + OUT_W'(bits[i]);
    end
  end

  assign count = count_s;

endmodule

// File: rtl/bit_population_counter_stream.sv
// Streaming bit population counter: one CHUNK_W slice per clock, early exit on empty remainder.
// Optional parity_o output enabled by BIT_POPULATION_COUNTER_STREAM_PARITY_EN.
module bit_population_counter_stream
  import bit_population_counter_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int CHUNK_W = 4
) (
  input  logic                            clk_i,
  input  logic                            arst_i,
  input  logic [DATA_W-1:0]               data_i,
  input  logic                            mode_i,
  input  logic                            data_val_i,
  output logic                            data_ready_o,
  output logic [result_width(DATA_W)-1:0] data_o,
  output logic                            data_val_o,
  input  logic                            data_ready_i
`ifdef BIT_POPULATION_COUNTER_STREAM_PARITY_EN
  ,
  output logic                            parity_o
`endif
);

  localparam int NCHUNK  = DATA_W / CHUNK_W;
  localparam int RES_W   = result_width(DATA_W);
  localparam int CHUNK_R = $clog2(CHUNK_W + 1);
  localparam int CNT_W   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  state_t             state_r;
  logic [DATA_W-1:0]  shift_r;
  logic [RES_W-1:0]   acc_r;
  logic [CNT_W-1:0]   chunk_idx_r;
  logic [RES_W-1:0]   data_r;
  logic               val_r;
  logic               rdy_r;

  logic [CHUNK_W-1:0] chunk_bits_s;
  logic [CHUNK_R-1:0] chunk_cnt_s;
  logic [RES_W-1:0]   acc_next_s;
  logic [DATA_W-1:0]  shift_next_s;
  logic               last_chunk_s;

  assign chunk_bits_s = shift_r[CHUNK_W-1:0];

  popcount_chunk #(
    .CHUNK_W(CHUNK_W)
  ) u_popcount_chunk (
    .bits (chunk_bits_s),
    .count(chunk_cnt_s)
  );

  assign acc_next_s   = acc_r + RES_W'(chunk_cnt_s);
  assign shift_next_s = shift_r >> CHUNK_W;
  assign last_chunk_s = (chunk_idx_r == CNT_W'(NCHUNK - 1));

`ifdef BIT_POPULATION_COUNTER_STREAM_PARITY_EN
  logic parity_r;

  // Parity of the result, valid only while the result is presented.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      parity_r <= 1'b0;
    end else if ((state_r == ST_COUNT) && (last_chunk_s || (shift_next_s == {DATA_W{1'b0}}))) begin
      parity_r <= acc_next_s[0];
    end else if ((state_r == ST_OUT) && data_ready_i) begin
      parity_r <= 1'b0;
    end else begin
      parity_r <= parity_r;
    end
  end

  assign parity_o = parity_r;
`endif

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_r     <= ST_IDLE;
      shift_r     <= {DATA_W{1'b0}};
      acc_r       <= {RES_W{1'b0}};
      chunk_idx_r <= {CNT_W{1'b0}};
      data_r      <= {RES_W{1'b0}};
      val_r       <= 1'b0;
      rdy_r       <= 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (data_val_i) begin
            shift_r     <= mode_i ? ~data_i : data_i;
            acc_r       <= {RES_W{1'b0}};
            chunk_idx_r <= {CNT_W{1'b0}};
            rdy_r       <= 1'b0;
            state_r     <= ST_COUNT;
          end
        end
        ST_COUNT: begin
          acc_r       <= acc_next_s;
          shift_r     <= shift_next_s;
          chunk_idx_r <= chunk_idx_r + CNT_W'(1);
          // Stop once every chunk is consumed or nothing set remains.
          if (last_chunk_s || (shift_next_s == {DATA_W{1'b0}})) begin
            data_r  <= acc_next_s;
            val_r   <= 1'b1;
            state_r <= ST_OUT;
          end
        end
        ST_OUT: begin
          if (data_ready_i) begin
            data_r  <= {RES_W{1'b0}};
            val_r   <= 1'b0;
            rdy_r   <= 1'b1;
            state_r <= ST_IDLE;
          end
        end
        default: begin
          data_r  <= {RES_W{1'b0}};
          val_r   <= 1'b0;
          rdy_r   <= 1'b1;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign data_ready_o = rdy_r;
  assign data_val_o   = val_r;
  assign data_o       = data_r;

endmodule
